// File: rtl/detect_pkg.sv
// -----------------------------------------------------------------------------
// detect_pkg
// Shared definitions for the detector statistics block: the FSM state
// encodings and the default counter width.
// -----------------------------------------------------------------------------
package detect_pkg;

    // Default width of every counter and snapshot field.
    localparam int CW_DEFAULT = 8;

    // IDLE : waiting for z to rise
    // RUN  : inside a counted run of z
    // WAIT : z was high when the statistics were cleared; the partial run is
    //        not counted, so wait for z to fall before arming again
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

endpackage : detect_pkg

// File: rtl/detect_stats_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones instead of wrapping.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset, zeroes the count
//   inc        - increment by one (ignored once saturated)
//   clr        - synchronous clear to zero (highest priority)
//   load       - synchronous load of load_value (beats inc)
//   load_value - value taken when load is high
//   value      - current registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] SAT_MAX = '1;

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_value;
        end else if (inc && (value_q != SAT_MAX)) begin
            value_d = value_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule : sat_counter

// File: rtl/detect_stats.sv
// -----------------------------------------------------------------------------
// detect_stats
// Collects statistics on the output z of a sequence detector: number of runs
// (events), length of the current run, longest run seen and length of the
// most recently completed run. A snapshot of (events, longest run) can be
// captured and handed to a consumer over a valid/ready handshake.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   z           - detector output, sampled every cycle
//   clear       - synchronous clear of all statistics (not the snapshot)
//   snap_req    - request a snapshot capture
//   snap_ready  - consumer accepts the held snapshot
//   snap_valid  - snapshot held and valid
//   snap_events - captured event count
//   snap_maxrun - captured longest run
//   run_active  - registered: FSM is in RUN
//   last_run    - length of the most recently completed run
// -----------------------------------------------------------------------------
module detect_stats
    import detect_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          z,
    input  logic          clear,
    input  logic          snap_req,
    input  logic          snap_ready,
    output logic          snap_valid,
    output logic [CW-1:0] snap_events,
    output logic [CW-1:0] snap_maxrun,
    output logic          run_active,
    output logic [CW-1:0] last_run
);

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q, state_d;
    logic          run_active_q, run_active_d;
    logic [CW-1:0] last_run_q, last_run_d;
    logic          snap_valid_q, snap_valid_d;
    logic [CW-1:0] snap_events_q, snap_events_d;
    logic [CW-1:0] snap_maxrun_q, snap_maxrun_d;

    // Counter controls and values
    logic          event_inc;
    logic          cur_inc;
    logic          cur_start;
    logic          cur_end;
    logic          max_load;
    logic [CW-1:0] event_count;
    logic [CW-1:0] cur_run;
    logic [CW-1:0] max_run;

    // -------------------------------------------------------------------------
    // FSM next state and counter controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        last_run_d = last_run_q;
        event_inc  = 1'b0;
        cur_inc    = 1'b0;
        cur_start  = 1'b0;
        cur_end    = 1'b0;
        max_load   = 1'b0;

        if (clear) begin
            // A run in progress at clear time is abandoned; WAIT keeps it
            // from being counted when it later ends.
            state_d    = z ? ST_WAIT : ST_IDLE;
            last_run_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (z) begin
                        state_d   = ST_RUN;
                        cur_start = 1'b1;
                        event_inc = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (z) begin
                        cur_inc = 1'b1;
                    end else begin
                        state_d    = ST_IDLE;
                        last_run_d = cur_run;
                        cur_end    = 1'b1;
                        max_load   = (cur_run > max_run);
                    end
                end
                ST_WAIT: begin
                    if (!z) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // run_active is registered from the next state, so it lines up with
    // state_q == ST_RUN without any combinational path from z.
    assign run_active_d = (state_d == ST_RUN);

    // -------------------------------------------------------------------------
    // Snapshot handshake: capture only when nothing is held; a held snapshot
    // is released only by snap_ready and is untouched by clear.
    // -------------------------------------------------------------------------
    always_comb begin
        snap_valid_d  = snap_valid_q;
        snap_events_d = snap_events_q;
        snap_maxrun_d = snap_maxrun_q;
        if (snap_valid_q) begin
            if (snap_ready) begin
                snap_valid_d = 1'b0;
            end
        end else if (snap_req) begin
            snap_valid_d  = 1'b1;
            snap_events_d = event_count;
            snap_maxrun_d = max_run;
        end
    end

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    sat_counter #(.W(CW)) u_event_count (
        .clk        (clk),
        .reset      (reset),
        .inc        (event_inc),
        .clr        (clear),
        .load       (1'b0),
        .load_value ('0),
        .value      (event_count)
    );

    // A new run starts at 1 via load, so the start edge already counts the
    // first high cycle.
    sat_counter #(.W(CW)) u_cur_run (
        .clk        (clk),
        .reset      (reset),
        .inc        (cur_inc),
        .clr        (clear | cur_end),
        .load       (cur_start),
        .load_value (ONE),
        .value      (cur_run)
    );

    sat_counter #(.W(CW)) u_max_run (
        .clk        (clk),
        .reset      (reset),
        .inc        (1'b0),
        .clr        (clear),
        .load       (max_load),
        .load_value (cur_run),
        .value      (max_run)
    );

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            run_active_q  <= 1'b0;
            last_run_q    <= '0;
            snap_valid_q  <= 1'b0;
            snap_events_q <= '0;
            snap_maxrun_q <= '0;
        end else begin
            state_q       <= state_d;
            run_active_q  <= run_active_d;
            last_run_q    <= last_run_d;
            snap_valid_q  <= snap_valid_d;
            snap_events_q <= snap_events_d;
            snap_maxrun_q <= snap_maxrun_d;
        end
    end

    assign snap_valid  = snap_valid_q;
    assign snap_events = snap_events_q;
    assign snap_maxrun = snap_maxrun_q;
    assign run_active  = run_active_q;
    assign last_run    = last_run_q;

endmodule : detect_stats

// File: tb/tb_detect_stats.sv
// -----------------------------------------------------------------------------
// tb_detect_stats
// Drives a CW=8 and a CW=4 instance of detect_stats with the same directed
// stimulus. Expected snapshots are queued when a capture is requested; a
// monitor per instance compares every cycle a snapshot is held and retires
// the entry on acceptance.
// -----------------------------------------------------------------------------
module tb_detect_stats;

    typedef struct {
        int ev;
        int mx;
    } snap_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic z = 1'b0;
    logic clear = 1'b0;
    logic snap_req = 1'b0;
    logic snap_ready = 1'b0;

    logic       sv8, ra8;
    logic [7:0] se8, sm8, lr8;
    logic       sv4, ra4;
    logic [3:0] se4, sm4, lr4;

    snap_t q8[$];
    snap_t q4[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    detect_stats #(.CW(8)) dut8 (
        .clk(clk), .reset(reset), .z(z), .clear(clear),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .snap_valid(sv8), .snap_events(se8), .snap_maxrun(sm8),
        .run_active(ra8), .last_run(lr8)
    );

    detect_stats #(.CW(4)) dut4 (
        .clk(clk), .reset(reset), .z(z), .clear(clear),
        .snap_req(snap_req), .snap_ready(snap_ready),
        .snap_valid(sv4), .snap_events(se4), .snap_maxrun(sm4),
        .run_active(ra4), .last_run(lr4)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk2(input string name, input int a8, input int a4,
                        input int e8, input int e4);
        chk({name, "_cw8"}, a8, e8);
        chk({name, "_cw4"}, a4, e4);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // z high for n cycles, then one low cycle so the run ends.
    task automatic run_len(input int n);
        z = 1'b1;
        repeat (n) tick();
        z = 1'b0;
        tick();
    endtask

    task automatic snap(input int e8, input int m8, input int e4, input int m4);
        snap_t s;
        s.ev = e8; s.mx = m8; q8.push_back(s);
        s.ev = e4; s.mx = m4; q4.push_back(s);
        $display("snap request: expect cw8 (%0d,%0d) cw4 (%0d,%0d)", e8, m8, e4, m4);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk2("snap_valid_raised", sv8, sv4, 1, 1);
    endtask

    task automatic accept();
        snap_ready = 1'b1;
        tick();
        snap_ready = 1'b0;
        chk2("snap_valid_fell", sv8, sv4, 0, 0);
    endtask

    // Monitors: compare the held snapshot every cycle; retire on acceptance.
    always @(negedge clk) begin
        if (!reset && sv8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snap_unexpected_cw8 actual=(%0d,%0d) required=none", se8, sm8);
            end else begin
                chk("snap_events_cw8", int'(se8), q8[0].ev);
                chk("snap_maxrun_cw8", int'(sm8), q8[0].mx);
                if (snap_ready) begin
                    $display("snap accepted cw8 (%0d,%0d)", se8, sm8);
                    void'(q8.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && sv4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snap_unexpected_cw4 actual=(%0d,%0d) required=none", se4, sm4);
            end else begin
                chk("snap_events_cw4", int'(se4), q4[0].ev);
                chk("snap_maxrun_cw4", int'(sm4), q4[0].mx);
                if (snap_ready) begin
                    $display("snap accepted cw4 (%0d,%0d)", se4, sm4);
                    void'(q4.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk2("reset_run_active", ra8, ra4, 0, 0);
        chk2("reset_last_run", lr8, lr4, 0, 0);
        chk2("reset_snap_valid", sv8, sv4, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single run of 3
        z = 1'b1;
        tick(); chk2("run3_active_c1", ra8, ra4, 1, 1);
        tick(); chk2("run3_active_c2", ra8, ra4, 1, 1);
        tick(); chk2("run3_active_c3", ra8, ra4, 1, 1);
        z = 1'b0;
        tick(); chk2("run3_active_end", ra8, ra4, 0, 0);
        chk2("run3_last_run", lr8, lr4, 3, 3);
        snap(1, 3, 1, 3);
        accept();

        // Runs of 2, 5, 4 after a clear
        clear = 1'b1; tick(); clear = 1'b0;
        chk2("clear_last_run", lr8, lr4, 0, 0);
        run_len(2);
        run_len(5);
        run_len(4);
        chk2("runs_last_run", lr8, lr4, 4, 4);
        snap(3, 5, 3, 5);

        // Hold with new runs and an ignored request, then accept with a
        // simultaneous (ignored) request
        run_len(1);
        snap_req = 1'b1; tick(); snap_req = 1'b0;
        run_len(2);
        chk2("hold_snap_valid", sv8, sv4, 1, 1);
        snap_req = 1'b1; snap_ready = 1'b1;
        tick();
        snap_req = 1'b0; snap_ready = 1'b0;
        chk2("accept_req_ignored", sv8, sv4, 0, 0);
        chk2("hold_last_run", lr8, lr4, 2, 2);
        snap(5, 5, 5, 5);
        accept();

        // clear together with snap_req captures pre-clear values; clear while
        // held leaves the snapshot alone
        q8.push_back('{5, 5});
        q4.push_back('{5, 5});
        snap_req = 1'b1; clear = 1'b1;
        tick();
        snap_req = 1'b0;
        tick();
        clear = 1'b0;
        accept();
        snap(0, 0, 0, 0);
        accept();

        // clear mid-run: WAIT until z falls, nothing counted
        z = 1'b1;
        tick(); tick();
        clear = 1'b1; tick(); clear = 1'b0;
        chk2("clear_midrun_active", ra8, ra4, 0, 0);
        tick(); tick();
        chk2("wait_active", ra8, ra4, 0, 0);
        z = 1'b0;
        tick();
        chk2("wait_last_run", lr8, lr4, 0, 0);
        snap(0, 0, 0, 0);
        accept();
        run_len(2);
        chk2("after_wait_last_run", lr8, lr4, 2, 2);
        snap(1, 2, 1, 2);
        accept();

        // Saturation: long run of 20, then 17 single-cycle pulses
        clear = 1'b1; tick(); clear = 1'b0;
        run_len(20);
        chk2("long_last_run", lr8, lr4, 20, 15);
        repeat (17) run_len(1);
        chk2("pulse_last_run", lr8, lr4, 1, 1);
        snap(18, 20, 15, 15);
        accept();

        // Reset between edges in mid-run with a held snapshot
        z = 1'b1;
        tick(); tick();
        snap(19, 20, 15, 15);
        #2;
        reset = 1'b1;
        q8.delete();
        q4.delete();
        #1;
        chk2("rst_run_active", ra8, ra4, 0, 0);
        chk2("rst_last_run", lr8, lr4, 0, 0);
        chk2("rst_snap_valid", sv8, sv4, 0, 0);
        chk2("rst_snap_events", se8, se4, 0, 0);
        chk2("rst_snap_maxrun", sm8, sm4, 0, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk2("post_rst_active", ra8, ra4, 1, 1);
        z = 1'b0;
        tick();
        chk2("post_rst_last_run", lr8, lr4, 1, 1);
        snap(1, 1, 1, 1);
        accept();

        tick();
        chk("queue_drained_cw8", q8.size(), 0);
        chk("queue_drained_cw4", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_detect_stats
